regfile_wb_scheduler: RTL and testbench

- Controls the single write port of the 32x32 register file.
- Arbitrates between two writeback sources, the ALU path and the memory/load path. At most one register write occurs per cycle.
- Keeps a busy scoreboard of destination registers with writes still in flight, and stalls decode on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file. Its outputs drive enable_reg_write, addr_write and write_data directly.

---
 rtl/regfile_wb_scheduler_if.sv | 45 ++++
 rtl/regfile_wb_scheduler.sv | 128 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of decode-issue, ALU/load writeback and register-file write signals
// shared between the writeback scheduler and its neighbours.
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            issue_stall;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic            enable_reg_write;
    logic [AW-1:0]   addr_write;
    logic [XLEN-1:0] write_data;
    logic [NREG-1:0] busy_vec;

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output issue_stall, alu_ready, mem_ready,
        output enable_reg_write, addr_write, write_data, busy_vec
    );

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  issue_stall, alu_ready, mem_ready,
        input  enable_reg_write, addr_write, write_data, busy_vec
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Single-write-port scheduler for the register file: round-robin ALU/load
// arbitration, registered write port and a busy scoreboard for RAW/WAW stalls.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic                    clk,
    input logic                    reset,
    regfile_wb_scheduler_if.slave  wb
);
    localparam int AW = $clog2(NREG);

    // Which requester wins the next tie.
    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } rr_e;

    rr_e             rr_q, rr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            grant_alu;
    logic            grant_mem;
    logic            grant_any;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            issue_stall;
    logic            issue_fire;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Arbitration; reset suppresses grants so no handshake completes under it.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        rr_d      = rr_q;
        if (!reset) begin
            if (wb.alu_valid && wb.mem_valid) begin
                if (rr_q == PRI_MEM) begin
                    grant_mem = 1'b1;
                    rr_d      = PRI_ALU;
                end else begin
                    grant_alu = 1'b1;
                    rr_d      = PRI_MEM;
                end
            end else if (wb.alu_valid) begin
                grant_alu = 1'b1;
            end else if (wb.mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any  = grant_alu | grant_mem;
        grant_rd   = grant_mem ? wb.mem_rd   : wb.alu_rd;
        grant_data = grant_mem ? wb.mem_data : wb.alu_data;
    end

    // Stall looks only at the registered scoreboard; no same-cycle bypass.
    always_comb begin
        issue_stall = wb.issue_valid &
                      (busy_q[wb.rs1_addr] | busy_q[wb.rs2_addr] | busy_q[wb.issue_rd]);
        issue_fire  = wb.issue_valid & ~issue_stall & (wb.issue_rd != '0) & ~reset;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
            end else begin : g_xn
                assign set_vec[gi] = issue_fire && (wb.issue_rd == AW'(gi));
                assign clr_vec[gi] = grant_any && (grant_rd == AW'(gi));
            end
        end
    endgenerate

    // Set takes priority over clear when both hit the same register.
    always_comb begin
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // A granted rd=0 completes the handshake but never reaches the file.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_any && (grant_rd != '0)) begin
            we_d    = 1'b1;
            waddr_d = grant_rd;
            wdata_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= PRI_MEM;
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb.issue_stall      = issue_stall;
    assign wb.alu_ready        = grant_alu;
    assign wb.mem_ready        = grant_mem;
    assign wb.enable_reg_write = we_q;
    assign wb.addr_write       = waddr_q;
    assign wb.write_data       = wdata_q;
    assign wb.busy_vec         = busy_q;

    a_single_grant: assert property (@(posedge clk) !(grant_alu && grant_mem));
    a_x0_idle:      assert property (@(posedge clk) disable iff (reset) !busy_q[0]);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected register-file writes are
// queued at grant time and checked by an independent write-port monitor.
module tb_regfile_wb_scheduler;
    logic clk;
    logic reset;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_cmp;
    int n_fail;

    regfile_wb_scheduler_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
    endtask

    task automatic randomize_inputs();
        bus.issue_valid = 1'($urandom);
        bus.issue_rd    = 5'($urandom);
        bus.rs1_addr    = 5'($urandom);
        bus.rs2_addr    = 5'($urandom);
        bus.alu_valid   = 1'($urandom);
        bus.alu_rd      = 5'($urandom);
        bus.alu_data    = $urandom;
        bus.mem_valid   = 1'($urandom);
        bus.mem_rd      = 5'($urandom);
        bus.mem_data    = $urandom;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        reset = 1'b0;
        idle();
        #1;
        chk("rst_busy_vec", bus.busy_vec, 32'h0);
        chk("rst_enable", 32'(bus.enable_reg_write), 32'h0);
        chk("rst_addr_write", 32'(bus.addr_write), 32'h0);
        chk("rst_write_data", bus.write_data, 32'h0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    endtask

    // Write-port monitor: every write the DUT presents must match the queue head.
    always @(negedge clk) begin
        wb_exp_t e;
        if (bus.enable_reg_write === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         bus.addr_write, bus.write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.addr_write !== e.rd || bus.write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_port: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                             bus.addr_write, bus.write_data, e.rd, e.data);
                end else begin
                    $display("ok   write_port: addr %0d data 0x%08h", e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();
        reset_dut();

        // RAW on x5
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        #1 chk("raw_issue_stall0", 32'(bus.issue_stall), 32'h0);
        step();
        chk("raw_busy_set", bus.busy_vec, 32'h0000_0020);
        bus.rs1_addr = 5'd5; bus.issue_rd = 5'd6;
        #1 chk("raw_stall_c1", 32'(bus.issue_stall), 32'h1);
        step();
        chk("raw_busy_hold", bus.busy_vec, 32'h0000_0020);
        #1 chk("raw_stall_c2", 32'(bus.issue_stall), 32'h1);
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        push_exp(5'd5, 32'hDEAD_BEEF);
        #1;
        chk("raw_alu_ready", 32'(bus.alu_ready), 32'h1);
        chk("raw_mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("raw_stall_grant", 32'(bus.issue_stall), 32'h1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        chk("raw_we", 32'(bus.enable_reg_write), 32'h1);
        chk("raw_addr", 32'(bus.addr_write), 32'd5);
        chk("raw_data", bus.write_data, 32'hDEAD_BEEF);
        chk("raw_busy_clr", bus.busy_vec, 32'h0);
        chk("raw_stall_released", 32'(bus.issue_stall), 32'h0);
        bus.issue_valid = 1'b0; bus.rs1_addr = '0;
        step();

        // Contention: mem wins first tie after reset, alu the next
        reset_dut();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h22;
        push_exp(5'd4, 32'h22);
        #1;
        chk("tie1_mem_ready", 32'(bus.mem_ready), 32'h1);
        chk("tie1_alu_ready", 32'(bus.alu_ready), 32'h0);
        step();
        bus.mem_valid = 1'b0;
        push_exp(5'd3, 32'h11);
        #1;
        chk("tie1_alu_next", 32'(bus.alu_ready), 32'h1);
        chk("tie1_we", 32'(bus.enable_reg_write), 32'h1);
        chk("tie1_addr", 32'(bus.addr_write), 32'd4);
        step();
        bus.alu_valid = 1'b0;
        chk("tie1b_addr", 32'(bus.addr_write), 32'd3);
        chk("tie1b_data", bus.write_data, 32'h11);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h33;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h44;
        push_exp(5'd8, 32'h33);
        #1;
        chk("tie2_alu_ready", 32'(bus.alu_ready), 32'h1);
        chk("tie2_mem_ready", 32'(bus.mem_ready), 32'h0);
        step();
        bus.alu_valid = 1'b0;
        push_exp(5'd9, 32'h44);
        #1;
        chk("tie2_mem_next", 32'(bus.mem_ready), 32'h1);
        chk("tie2_addr", 32'(bus.addr_write), 32'd8);
        step();
        bus.mem_valid = 1'b0;
        chk("tie2b_addr", 32'(bus.addr_write), 32'd9);

        // x0: no scoreboard entry, handshake completes, no write
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        #1 chk("x0_stall", 32'(bus.issue_stall), 32'h0);
        step();
        bus.issue_valid = 1'b0;
        chk("x0_busy", bus.busy_vec, 32'h0);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFF_FFFF;
        #1 chk("x0_mem_ready", 32'(bus.mem_ready), 32'h1);
        step();
        bus.mem_valid = 1'b0;
        chk("x0_we", 32'(bus.enable_reg_write), 32'h0);
        chk("x0_addr_hold", 32'(bus.addr_write), 32'd9);
        chk("x0_data_hold", bus.write_data, 32'h44);

        // Same-cycle set and clear of x10: set wins
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0A0;
        push_exp(5'd10, 32'hA0A0);
        #1 chk("setwin_alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        bus.issue_valid = 1'b0; bus.alu_valid = 1'b0;
        chk("setwin_busy", bus.busy_vec, 32'h0000_0400);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'hB0B0;
        push_exp(5'd10, 32'hB0B0);
        step();
        bus.mem_valid = 1'b0;
        chk("setwin_clear", bus.busy_vec, 32'h0);

        // WAW on x7
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        #1 chk("waw_first_stall", 32'(bus.issue_stall), 32'h0);
        step();
        chk("waw_busy", bus.busy_vec, 32'h0000_0080);
        #1 chk("waw_second_stall", 32'(bus.issue_stall), 32'h1);
        step();
        chk("waw_busy_hold", bus.busy_vec, 32'h0000_0080);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h77;
        push_exp(5'd7, 32'h77);
        #1;
        chk("waw_mem_ready", 32'(bus.mem_ready), 32'h1);
        chk("waw_stall_grant", 32'(bus.issue_stall), 32'h1);
        step();
        bus.mem_valid = 1'b0;
        #1;
        chk("waw_we", 32'(bus.enable_reg_write), 32'h1);
        chk("waw_busy_clr", bus.busy_vec, 32'h0);
        chk("waw_stall_release", 32'(bus.issue_stall), 32'h0);
        step();
        bus.issue_valid = 1'b0;
        chk("waw_reissued", bus.busy_vec, 32'h0000_0080);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h78;
        push_exp(5'd7, 32'h78);
        step();
        bus.alu_valid = 1'b0;
        chk("waw_final_clear", bus.busy_vec, 32'h0);

        // Reset mid-operation drops in-flight state
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
        step();
        bus.issue_rd = 5'd9;
        step();
        bus.issue_rd = 5'd31;
        step();
        bus.issue_valid = 1'b0;
        chk("mid_busy_set", bus.busy_vec, 32'h8000_0204);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h55;
        reset = 1'b1;
        #1 chk("mid_alu_ready", 32'(bus.alu_ready), 32'h0);
        step();
        reset = 1'b0;
        bus.alu_valid = 1'b0;
        chk("mid_busy_clr", bus.busy_vec, 32'h0);
        chk("mid_we", 32'(bus.enable_reg_write), 32'h0);
        step();
        chk("mid_we_after", 32'(bus.enable_reg_write), 32'h0);

        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
